// File: rtl/edusoc_bus_pkg.sv
// Shared definitions for the EduSoC CPU-side data bus: arbiter FSM
// encoding and the read data returned on a bus timeout.
package edusoc_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    // Read data handed back to a master whose access timed out.
    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/edusoc_rr_picker.sv
// Round-robin picker: finds the first set request bit at or above ptr,
// wrapping modulo N. Purely combinational so it can also serve the
// interrupt arbiter.
module edusoc_rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    logic [PTR_W-1:0] cand;

    // Wrap helper: ptr is always < N, so one subtraction is enough.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'(wrap_idx(int'(ptr), i));
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/edusoc_data_arbiter.sv
// N-to-1 round-robin arbiter for the EduSoC DATA port with an optional
// timeout that completes a hung access with an error response.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access downstream; pick next requester from rr_ptr
// BUSY    | granted master's access driven downstream until DATA_VALID
//         | or the timeout expires
module edusoc_data_arbiter
    import edusoc_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 0,
    localparam int BE_W       = DATA_W / 8,
    localparam int ID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          CPU_CLK,
    input  logic                          CPU_RES,
    input  logic [NUM_MASTERS-1:0]        M_REQ,
    input  logic [NUM_MASTERS-1:0]        M_WE,
    input  logic [NUM_MASTERS*BE_W-1:0]   M_BE,
    input  logic [NUM_MASTERS*ADDR_W-1:0] M_ADDR,
    input  logic [NUM_MASTERS*DATA_W-1:0] M_WDATA,
    output logic [NUM_MASTERS-1:0]        M_VALID,
    output logic [NUM_MASTERS-1:0]        M_ERR,
    output logic [DATA_W-1:0]             M_RDATA,
    output logic                          DATA_REQ,
    output logic                          DATA_WE,
    output logic [BE_W-1:0]               DATA_BE,
    output logic [ADDR_W-1:0]             DATA_ADDR,
    output logic [DATA_W-1:0]             DATA_WDATA,
    input  logic                          DATA_VALID,
    input  logic [DATA_W-1:0]             DATA_RDATA,
    output logic [ID_W-1:0]               GRANT_ID
);

    localparam int  CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  TMO_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  TMO_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(BUS_ERR_RDATA);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_MASTERS - 1);

    bus_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_index;

    logic             busy;
    logic             done;
    logic             expire;

    edusoc_rr_picker #(
        .N     (NUM_MASTERS),
        .PTR_W (ID_W)
    ) u_picker (
        .req   (M_REQ),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .index (pick_index)
    );

    // A completion in the reset cycle is dropped, so both completion
    // sources are gated by CPU_RES. A real DATA_VALID beats a timeout
    // that lands in the same cycle.
    assign busy   = (state_q == ST_BUSY);
    assign done   = busy && DATA_VALID && !CPU_RES;
    assign expire = TMO_EN && busy && !DATA_VALID && !CPU_RES
                    && (tmo_cnt_q == TMO_LAST);

    assign GRANT_ID = grant_q;

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RES) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Next-state logic: grant on request, release on completion/timeout.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_BUSY;
                    grant_d   = pick_index;
                    tmo_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (done || expire) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Downstream request mux and upstream completion steering; everything
    // is held at zero outside BUSY so idle masters see a quiet bus.
    always_comb begin
        DATA_REQ   = busy;
        DATA_WE    = 1'b0;
        DATA_BE    = '0;
        DATA_ADDR  = '0;
        DATA_WDATA = '0;
        M_VALID    = '0;
        M_ERR      = '0;
        M_RDATA    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (busy && (grant_q == ID_W'(i))) begin
                DATA_WE    = M_WE[i];
                DATA_BE    = M_BE[i*BE_W +: BE_W];
                DATA_ADDR  = M_ADDR[i*ADDR_W +: ADDR_W];
                DATA_WDATA = M_WDATA[i*DATA_W +: DATA_W];
                M_VALID[i] = done || expire;
                M_ERR[i]   = expire;
            end
        end
        if (done) begin
            M_RDATA = DATA_RDATA;
        end else if (expire) begin
            M_RDATA = ERR_RDATA;
        end
    end

endmodule

// File: tb/tb_edusoc_data_arbiter.sv
// Directed bench: instance A (3 masters, TIMEOUT=8) covers read, contention,
// write passthrough, timeout and reset mid-access; instance B (2 masters,
// TIMEOUT=4) covers the DATA_VALID/timeout race and the short timeout.
module tb_edusoc_data_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instance A
    logic        a_res;
    logic [2:0]  a_req, a_we, a_mvalid, a_merr;
    logic [11:0] a_be;
    logic [95:0] a_addr, a_wdata;
    logic [31:0] a_mrdata, a_daddr, a_dwdata, a_drdata;
    logic        a_dreq, a_dwe, a_dvalid;
    logic [3:0]  a_dbe;
    logic [1:0]  a_gid;

    // instance B
    logic        b_res;
    logic [1:0]  b_req, b_we, b_mvalid, b_merr;
    logic [7:0]  b_be;
    logic [63:0] b_addr, b_wdata;
    logic [31:0] b_mrdata, b_daddr, b_dwdata, b_drdata;
    logic        b_dreq, b_dwe, b_dvalid;
    logic [3:0]  b_dbe;
    logic [0:0]  b_gid;

    edusoc_data_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut_a (
        .CPU_CLK(clk), .CPU_RES(a_res),
        .M_REQ(a_req), .M_WE(a_we), .M_BE(a_be), .M_ADDR(a_addr), .M_WDATA(a_wdata),
        .M_VALID(a_mvalid), .M_ERR(a_merr), .M_RDATA(a_mrdata),
        .DATA_REQ(a_dreq), .DATA_WE(a_dwe), .DATA_BE(a_dbe), .DATA_ADDR(a_daddr),
        .DATA_WDATA(a_dwdata), .DATA_VALID(a_dvalid), .DATA_RDATA(a_drdata),
        .GRANT_ID(a_gid)
    );

    edusoc_data_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_b (
        .CPU_CLK(clk), .CPU_RES(b_res),
        .M_REQ(b_req), .M_WE(b_we), .M_BE(b_be), .M_ADDR(b_addr), .M_WDATA(b_wdata),
        .M_VALID(b_mvalid), .M_ERR(b_merr), .M_RDATA(b_mrdata),
        .DATA_REQ(b_dreq), .DATA_WE(b_dwe), .DATA_BE(b_dbe), .DATA_ADDR(b_daddr),
        .DATA_WDATA(b_dwdata), .DATA_VALID(b_dvalid), .DATA_RDATA(b_drdata),
        .GRANT_ID(b_gid)
    );

    task automatic test_reset();
        a_res = 1'b1; a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
        a_dvalid = 1'b0; a_drdata = '0;
        b_res = 1'b1; b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
        b_dvalid = 1'b0; b_drdata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({a_dreq, a_dwe, a_dbe, a_daddr, a_dwdata, a_mvalid, a_merr, a_mrdata, a_gid} !== '0) begin
            n_fail++;
            $display("FAIL reset_a_outputs: got req=%b we=%b be=%h addr=%h wd=%h v=%b e=%b rd=%h gid=%0d, want all 0",
                     a_dreq, a_dwe, a_dbe, a_daddr, a_dwdata, a_mvalid, a_merr, a_mrdata, a_gid);
        end
        n_checks++;
        if ({b_dreq, b_dwe, b_dbe, b_daddr, b_dwdata, b_mvalid, b_merr, b_mrdata, b_gid} !== '0) begin
            n_fail++;
            $display("FAIL reset_b_outputs: got req=%b v=%b e=%b rd=%h gid=%0d, want all 0",
                     b_dreq, b_mvalid, b_merr, b_mrdata, b_gid);
        end
        @(negedge clk);
        a_res = 1'b0;
        b_res = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a_req = 3'b001; a_we = 3'b000; a_addr[31:0] = 32'h0000_1000;
        #1;
        n_checks++;
        if (a_dreq !== 1'b0) begin n_fail++; $display("FAIL rd_idle_req: got %b want 0", a_dreq); end
        @(negedge clk); #1;
        n_checks++;
        if (a_dreq !== 1'b1) begin n_fail++; $display("FAIL rd_req_latency: got %b want 1", a_dreq); end
        n_checks++;
        if (a_daddr !== 32'h0000_1000) begin n_fail++; $display("FAIL rd_addr: got %h want 00001000", a_daddr); end
        n_checks++;
        if (a_gid !== 2'd0) begin n_fail++; $display("FAIL rd_gid: got %0d want 0", a_gid); end
        n_checks++;
        if (a_mvalid !== 3'b000) begin n_fail++; $display("FAIL rd_early_valid: got %b want 000", a_mvalid); end
        @(negedge clk); #1;
        n_checks++;
        if ({a_dreq, a_mvalid} !== 4'b1_000) begin n_fail++; $display("FAIL rd_wait: got req=%b v=%b want 1/000", a_dreq, a_mvalid); end
        @(negedge clk);
        a_dvalid = 1'b1; a_drdata = 32'hCAFE_0001; a_req = 3'b000;
        #1;
        n_checks++;
        if (a_mvalid !== 3'b001) begin n_fail++; $display("FAIL rd_valid: got %b want 001", a_mvalid); end
        n_checks++;
        if (a_merr !== 3'b000) begin n_fail++; $display("FAIL rd_err: got %b want 000", a_merr); end
        n_checks++;
        if (a_mrdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rd_rdata: got %h want cafe0001", a_mrdata); end
        @(negedge clk);
        a_dvalid = 1'b0;
        #1;
        n_checks++;
        if ({a_dreq, a_mvalid, a_mrdata} !== '0) begin
            n_fail++;
            $display("FAIL rd_after: got req=%b v=%b rd=%h want 0/000/0", a_dreq, a_mvalid, a_mrdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_id;
        @(negedge clk);
        a_res = 1'b1; a_req = 3'b000;
        @(negedge clk);
        a_res = 1'b0; a_req = 3'b111; a_drdata = '0;
        for (int t = 0; t < 6; t++) begin
            exp_id = 2'(t % 3);
            @(negedge clk);
            a_dvalid = 1'b1; a_drdata = 32'hC0DE_0000 + 32'(t);
            #1;
            n_checks++;
            if (a_dreq !== 1'b1) begin n_fail++; $display("FAIL rr_req t=%0d: got %b want 1", t, a_dreq); end
            n_checks++;
            if (a_gid !== exp_id) begin n_fail++; $display("FAIL rr_gid t=%0d: got %0d want %0d", t, a_gid, exp_id); end
            n_checks++;
            if (a_mvalid !== (3'b001 << exp_id)) begin
                n_fail++; $display("FAIL rr_valid t=%0d: got %b want %b", t, a_mvalid, 3'b001 << exp_id);
            end
            n_checks++;
            if (a_mrdata !== 32'hC0DE_0000 + 32'(t)) begin
                n_fail++; $display("FAIL rr_rdata t=%0d: got %h want %h", t, a_mrdata, 32'hC0DE_0000 + 32'(t));
            end
            @(negedge clk);
            a_dvalid = 1'b0;
            #1;
            n_checks++;
            if (a_dreq !== 1'b0) begin n_fail++; $display("FAIL rr_gap t=%0d: got %b want 0", t, a_dreq); end
            if (t == 5) a_req = 3'b000;
        end
    endtask

    task automatic test_write_passthrough();
        @(negedge clk);
        a_req   = 3'b010;
        a_we    = 3'b010;
        a_be    = {4'hF, 4'b0101, 4'hF};
        a_addr  = {32'h3333_0000, 32'h0000_2004, 32'h1111_0000};
        a_wdata = {32'hAAAA_AAAA, 32'h55AA_55AA, 32'h1234_5678};
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({a_dreq, a_dwe, a_gid} !== 4'b1_1_01) begin
                n_fail++; $display("FAIL wr_ctrl c=%0d: got req=%b we=%b gid=%0d want 1/1/1", c, a_dreq, a_dwe, a_gid);
            end
            n_checks++;
            if (a_dbe !== 4'b0101) begin n_fail++; $display("FAIL wr_be c=%0d: got %b want 0101", c, a_dbe); end
            n_checks++;
            if (a_daddr !== 32'h0000_2004) begin n_fail++; $display("FAIL wr_addr c=%0d: got %h want 00002004", c, a_daddr); end
            n_checks++;
            if (a_dwdata !== 32'h55AA_55AA) begin n_fail++; $display("FAIL wr_wdata c=%0d: got %h want 55aa55aa", c, a_dwdata); end
        end
        @(negedge clk);
        a_dvalid = 1'b1; a_drdata = 32'h0; a_req = 3'b000;
        #1;
        n_checks++;
        if ({a_mvalid, a_merr} !== 6'b010_000) begin
            n_fail++; $display("FAIL wr_done: got v=%b e=%b want 010/000", a_mvalid, a_merr);
        end
        @(negedge clk);
        a_dvalid = 1'b0; a_we = 3'b000;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        a_req = 3'b100;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({a_dreq, a_mvalid, a_merr, a_gid} !== 9'b1_000_000_10) begin
                n_fail++;
                $display("FAIL tmo_wait c=%0d: got req=%b v=%b e=%b gid=%0d want 1/000/000/2", c, a_dreq, a_mvalid, a_merr, a_gid);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_mvalid, a_merr} !== 6'b100_100) begin
            n_fail++; $display("FAIL tmo_fire: got v=%b e=%b want 100/100", a_mvalid, a_merr);
        end
        n_checks++;
        if (a_mrdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_rdata: got %h want deadbeef", a_mrdata); end
        a_req = 3'b000;
        @(negedge clk);
        a_dvalid = 1'b1; a_drdata = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if ({a_dreq, a_mvalid, a_mrdata} !== '0) begin
            n_fail++; $display("FAIL tmo_late_valid: got req=%b v=%b rd=%h want 0/000/0", a_dreq, a_mvalid, a_mrdata);
        end
        @(negedge clk);
        a_dvalid = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        a_req = 3'b001;
        @(negedge clk);
        a_dvalid = 1'b1; a_drdata = 32'h1; a_req = 3'b000;
        #1;
        n_checks++;
        if (a_mvalid !== 3'b001) begin n_fail++; $display("FAIL rst_setup_valid: got %b want 001", a_mvalid); end
        @(negedge clk);
        a_dvalid = 1'b0; a_req = 3'b011;
        @(negedge clk); #1;
        n_checks++;
        if (a_gid !== 2'd1) begin n_fail++; $display("FAIL rst_pre_gid: got %0d want 1", a_gid); end
        @(negedge clk);
        a_res = 1'b1; a_dvalid = 1'b1; a_drdata = 32'h7777_7777;
        #1;
        n_checks++;
        if (a_mvalid !== 3'b000) begin n_fail++; $display("FAIL rst_drop_valid: got %b want 000", a_mvalid); end
        @(negedge clk);
        a_res = 1'b0; a_dvalid = 1'b0;
        #1;
        n_checks++;
        if ({a_dreq, a_dwe, a_dbe, a_daddr, a_dwdata, a_mvalid, a_merr, a_mrdata, a_gid} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got req=%b v=%b e=%b rd=%h gid=%0d want all 0", a_dreq, a_mvalid, a_merr, a_mrdata, a_gid);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_dreq, a_gid} !== 3'b1_00) begin
            n_fail++; $display("FAIL rst_regrant: got req=%b gid=%0d want 1/0", a_dreq, a_gid);
        end
        @(negedge clk);
        a_dvalid = 1'b1; a_req = 3'b000;
        #1;
        n_checks++;
        if (a_mvalid !== 3'b001) begin n_fail++; $display("FAIL rst_regrant_valid: got %b want 001", a_mvalid); end
        @(negedge clk);
        a_dvalid = 1'b0;
    endtask

    task automatic test_race_and_short_timeout();
        @(negedge clk);
        b_req = 2'b01; b_addr[31:0] = 32'h0000_0040;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({b_dreq, b_mvalid} !== 3'b1_00) begin
                n_fail++; $display("FAIL race_wait c=%0d: got req=%b v=%b want 1/00", c, b_dreq, b_mvalid);
            end
        end
        @(negedge clk);
        b_dvalid = 1'b1; b_drdata = 32'h1234_5678; b_req = 2'b00;
        #1;
        n_checks++;
        if ({b_mvalid, b_merr} !== 4'b01_00) begin
            n_fail++; $display("FAIL race_done: got v=%b e=%b want 01/00", b_mvalid, b_merr);
        end
        n_checks++;
        if (b_mrdata !== 32'h1234_5678) begin n_fail++; $display("FAIL race_rdata: got %h want 12345678", b_mrdata); end
        @(negedge clk);
        b_dvalid = 1'b0;
        #1;
        n_checks++;
        if (b_dreq !== 1'b0) begin n_fail++; $display("FAIL race_idle: got %b want 0", b_dreq); end
        b_req = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({b_dreq, b_mvalid, b_merr} !== 5'b1_00_00) begin
                n_fail++; $display("FAIL tmo4_wait c=%0d: got req=%b v=%b e=%b want 1/00/00", c, b_dreq, b_mvalid, b_merr);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({b_mvalid, b_merr, b_gid} !== 5'b10_10_1) begin
            n_fail++; $display("FAIL tmo4_fire: got v=%b e=%b gid=%0d want 10/10/1", b_mvalid, b_merr, b_gid);
        end
        n_checks++;
        if (b_mrdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo4_rdata: got %h want deadbeef", b_mrdata); end
        b_req = 2'b00;
        @(negedge clk); #1;
        n_checks++;
        if ({b_dreq, b_mvalid} !== 3'b0_00) begin
            n_fail++; $display("FAIL tmo4_after: got req=%b v=%b want 0/00", b_dreq, b_mvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_passthrough();
        test_timeout();
        test_reset_mid_busy();
        test_race_and_short_timeout();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
